// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared types and defaults for the FIFO memory sequencer and its arbiter.
package fifo_mem_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH = depth_of(ADDR_W_DEF);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/fifo_mem_ctrl_rr_arbiter2.sv
// Two-request round-robin arbiter: the request that was not served last wins a tie.
module rr_arbiter2
  import fifo_mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd,
  output logic o_prio_rd
);

  grant_e r_last_grant;

  // History only moves on an actual grant, so idle cycles keep the turn order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GNT_WR;
    end else if (o_gnt_wr) begin
      r_last_grant <= GNT_WR;
    end else if (o_gnt_rd) begin
      r_last_grant <= GNT_RD;
    end
  end

  assign o_prio_rd = (r_last_grant == GNT_WR);
  assign o_gnt_wr  = i_req_wr && !(i_req_rd && o_prio_rd);
  assign o_gnt_rd  = i_req_rd && !o_gnt_wr;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Circular-FIFO sequencer for a single-port register-file memory with a 1-entry output register.
// Optional statistics ports (stall_cnt, max_level) are built when FIFO_STATS_EN is defined.
module fifo_mem_ctrl
  import fifo_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_I,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_chipselect,
  input  logic [DATA_W-1:0] mem_O,
`ifdef FIFO_STATS_EN
  output logic [7:0]        stall_cnt,
  output logic [ADDR_W:0]   max_level,
`endif
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_mem_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  logic              w_full;
  logic              w_want_rd;
  logic              w_prio_rd;
  logic              w_req_wr;
  logic              w_req_rd;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic [ADDR_W:0]   w_level;

  assign w_full    = (r_mem_count == FULL_CNT);
  assign w_want_rd = (r_mem_count != '0) && (!r_out_valid || out_ready);
  assign w_req_wr  = in_valid && !flush && !w_full;
  assign w_req_rd  = !flush && w_want_rd;
  assign w_level   = r_mem_count + {{ADDR_W{1'b0}}, r_out_valid};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req_wr  (w_req_wr),
    .i_req_rd  (w_req_rd),
    .o_gnt_wr  (w_grant_wr),
    .o_gnt_rd  (w_grant_rd),
    .o_prio_rd (w_prio_rd)
  );

  // Ready is advertised without looking at in_valid so the producer never sees a loop.
  assign in_ready = !flush && !w_full && !(w_want_rd && w_prio_rd);

  assign mem_write      = w_grant_wr && reset;
  assign mem_read       = w_grant_rd && reset;
  assign mem_chipselect = w_grant_rd && reset;
  assign mem_address    = w_grant_wr ? r_wr_ptr : r_rd_ptr;
  assign mem_I          = in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_grant_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      // A refill in the same cycle as a pop keeps out_valid high.
      if (w_grant_rd) begin
        r_out_data  <= mem_O;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case ({w_grant_wr, w_grant_rd})
        2'b10:   r_mem_count <= r_mem_count + CNT_ONE;
        2'b01:   r_mem_count <= r_mem_count - CNT_ONE;
        default: r_mem_count <= r_mem_count;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign level     = w_level;
  assign full      = w_full;
  assign empty     = (w_level == '0);

`ifdef FIFO_STATS_EN
  logic [7:0]      r_stall_cnt;
  logic [ADDR_W:0] r_max_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_max_level <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
      r_max_level <= '0;
    end else begin
      if (in_valid && !in_ready && (r_stall_cnt != 8'hFF)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
      if (w_level > r_max_level) begin
        r_max_level <= w_level;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign max_level = r_max_level;
`endif

endmodule
